// File: rtl/wb_lcd_fetch_if.sv
// wb_lcd_fetch_if: Wishbone classic read bus plus valid/ready pixel stream for wb_lcd_fetch
interface wb_lcd_fetch_if;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;
  logic [31:0] pix_data;
  logic        pix_valid;
  logic        pix_ready;
  modport master (
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, pix_data, pix_valid,
    input  wb_dat_i, wb_ack_i, pix_ready
  );
  modport slave (
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, pix_data, pix_valid,
    output wb_dat_i, wb_ack_i, pix_ready
  );
endinterface

// File: rtl/wb_lcd_fetch.sv
// wb_lcd_fetch: Wishbone read initiator streaming a word block into a FWFT pixel FIFO; LCD_FETCH_TIMEOUT_EN adds an ack timeout
module wb_lcd_fetch #(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W = 16,
  parameter int TMO_CYCLES = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      base_addr,
  input  logic [CNT_W-1:0] word_count,
  output logic             busy,
  output logic             done,
  output logic             err,
  wb_lcd_fetch_if.master   bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, REQ, WAIT_ACK, DRAIN} state_t;
  state_t state, state_n;
  logic [31:0] addr, addr_n;
  logic [CNT_W-1:0] rem, rem_n;
  logic busy_n, done_n, push, pop, tmo_hit;
  logic [31:0] mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0] cnt;
  assign bus.wb_cyc_o = state == WAIT_ACK;
  assign bus.wb_stb_o = state == WAIT_ACK;
  assign bus.wb_we_o = 1'b0;
  assign bus.wb_sel_o = 4'b1111;
  assign bus.wb_adr_o = addr;
  assign bus.pix_valid = cnt != '0;
  assign bus.pix_data = bus.pix_valid ? mem[rd_ptr] : '0;
  assign push = bus.wb_cyc_o & bus.wb_ack_i;
  assign pop = bus.pix_valid & bus.pix_ready;
`ifdef LCD_FETCH_TIMEOUT_EN
  localparam int TW = $clog2(TMO_CYCLES + 1) < 8 ? 8 : $clog2(TMO_CYCLES + 1);
  logic [TW-1:0] tmo;
  assign tmo_hit = bus.wb_cyc_o & ~bus.wb_ack_i & (tmo == TW'(TMO_CYCLES - 1));
  // Cycles spent waiting on the current ack; restarts for every read
  always_ff @(posedge clk or posedge reset)
    if (reset) tmo <= '0;
    else tmo <= (bus.wb_cyc_o & ~bus.wb_ack_i) ? tmo + TW'(1) : '0;
  // Sticky timeout flag, cleared by a start accepted in IDLE
  always_ff @(posedge clk or posedge reset)
    if (reset) err <= 1'b0;
    else err <= (state == IDLE && start) ? 1'b0 : err | tmo_hit;
`else
  assign tmo_hit = TMO_CYCLES < 0;
  assign err = 1'b0;
`endif
  // FIFO storage; REQ only issues a read with a free entry, so a push never meets a full FIFO
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= bus.wb_dat_i;
  // FIFO pointers and occupancy; reset discards buffered words
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
    end
  // Control state and block bookkeeping registers
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      addr <= '0;
      rem <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      addr <= addr_n;
      rem <= rem_n;
      busy <= busy_n;
      done <= done_n;
    end
  // Next state: one read outstanding at a time, each gated by FIFO space
  always_comb begin
    state_n = state;
    addr_n = addr;
    rem_n = rem;
    busy_n = busy;
    done_n = 1'b0;
    case (state)
      IDLE:
        if (start && word_count != '0) begin
          state_n = REQ;
          addr_n = {base_addr[31:2], 2'b00};
          rem_n = word_count;
          busy_n = 1'b1;
        end else if (start) done_n = 1'b1;
      REQ:
        state_n = cnt != (AW+1)'(FIFO_DEPTH) ? WAIT_ACK : REQ;
      WAIT_ACK:
        if (bus.wb_ack_i) begin
          addr_n = addr + 32'd4;
          rem_n = rem - CNT_W'(1);
          state_n = rem == CNT_W'(1) ? DRAIN : REQ;
        end else if (tmo_hit) state_n = DRAIN;
      DRAIN:
        if (cnt == '0) begin
          state_n = IDLE;
          done_n = 1'b1;
          busy_n = 1'b0;
        end
      default: state_n = IDLE;
    endcase
  end
endmodule
